// File: rtl/matrix_scan_sequencer.sv
// Scan controller for a 16x16 LED matrix with 2-bit density per pixel.
// Fetches one row word from the frame buffer, expands it into a 32-bit
// row word for the current bit-plane, shifts it out LSB first, latches it
// and enables the row drivers for a fixed hold time.
module matrix_scan_sequencer #(
  parameter int CLK_DIV     = 4,
  parameter int HOLD_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        fb_rd_req,
  output logic [3:0]  fb_rd_row,
  input  logic        fb_rd_valid,
  input  logic [31:0] fb_rd_data,
  output logic        sclk,
  output logic        sdata,
  output logic        latch,
  output logic        oe_n,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LATCH,
    S_HOLD
  } state_t;

  localparam int MAXC = (CLK_DIV > HOLD_CYCLES) ? CLK_DIV : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t        state_q;
  logic [3:0]    row_q;
  logic [1:0]    plane_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    bit_q;
  logic          phase_q;
  logic [31:0]   sr_q;
  logic          req_q;
  logic          sclk_q;
  logic          sdata_q;
  logic          latch_q;
  logic          oe_n_q;
  logic          busy_q;
  logic          fdone_q;
  logic [31:0]   word_d;

  // Row word for the current row and plane: one-hot row select above the
  // column bits, a column lit when its density reaches the plane number.
  always_comb begin
    word_d        = '0;
    word_d[31:16] = 16'd1 << row_q;
    for (int unsigned c = 0; c < 16; c++) begin
      word_d[c] = (fb_rd_data[2*c +: 2] >= plane_q);
    end
  end

  // Scan FSM; every pin-facing output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      plane_q <= 2'd1;
      cnt_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      sr_q    <= '0;
      req_q   <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      fdone_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (fb_rd_valid) begin
            req_q   <= 1'b0;
            sr_q    <= word_d;
            sdata_q <= word_d[0];
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (!phase_q) begin
              sclk_q  <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              sclk_q  <= 1'b0;
              phase_q <= 1'b0;
              if (bit_q == 5'd31) begin
                latch_q <= 1'b1;
                state_q <= S_LATCH;
              end else begin
                // sr_q[0] is the bit just sent; the next one sits at [1]
                bit_q   <= bit_q + 5'd1;
                sr_q    <= sr_q >> 1;
                sdata_q <= sr_q[1];
              end
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_LATCH: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= '0;
            latch_q <= 1'b0;
            oe_n_q  <= 1'b0;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q  <= '0;
            oe_n_q <= 1'b1;
            row_q  <= row_q + 4'd1;
            if (row_q == 4'd15) begin
              plane_q <= (plane_q == 2'd3) ? 2'd1 : plane_q + 2'd1;
              fdone_q <= (plane_q == 2'd3);
            end
            if (enable) begin
              state_q <= S_FETCH;
              req_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fb_rd_req  = req_q;
  assign fb_rd_row  = row_q;
  assign sclk       = sclk_q;
  assign sdata      = sdata_q;
  assign latch      = latch_q;
  assign oe_n       = oe_n_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_matrix_scan_sequencer.sv
// Directed bench for matrix_scan_sequencer with CLK_DIV=1, HOLD_CYCLES=256.
// Expected row words are queued when the frame buffer answers and compared
// against the bits sampled on each sclk rise once the latch strobe appears.
module tb_matrix_scan_sequencer;
  localparam int HOLD = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fb_rd_req;
  logic [3:0]  fb_rd_row;
  logic        fb_rd_valid;
  logic [31:0] fb_rd_data;
  logic        sclk, sdata, latch, oe_n, busy, frame_done;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  matrix_scan_sequencer #(.CLK_DIV(1), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fb_rd_req(fb_rd_req), .fb_rd_row(fb_rd_row),
    .fb_rd_valid(fb_rd_valid), .fb_rd_data(fb_rd_data),
    .sclk(sclk), .sdata(sdata), .latch(latch), .oe_n(oe_n),
    .busy(busy), .frame_done(frame_done)
  );

  function automatic logic [31:0] model(input logic [31:0] pix, input int row, input int plane);
    logic [31:0] w;
    w = '0;
    w[16 + row] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      int d;
      d = int'(pix[2*c +: 2]);
      w[c] = (d >= plane);
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete row: fetch handshake, shift capture, latch and hold timing.
  task automatic run_row(input int erow, input int eplane, input logic [31:0] pix,
                         input int lat, input bit spur, input bit drop_en,
                         input bit do_rst, output logic [31:0] got);
    logic        seen;
    int          reqc, nb, lc, oec;
    logic        prev;
    logic [31:0] bits, expw;
    got  = '0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fb_rd_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("req_seen", seen, 1);
    if (!seen) return;
    chk("fetch_row", fb_rd_row, erow);
    reqc = 1;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (fb_rd_req) reqc++;
    end
    fb_rd_valid = 1'b1;
    fb_rd_data  = pix;
    exp_q.push_back(model(pix, erow, eplane));
    @(negedge clk);
    fb_rd_valid = 1'b0;
    fb_rd_data  = $urandom;
    chk("req_drop", fb_rd_req, 0);
    if (lat > 1) chk("req_held", reqc, lat);
    prev = 1'b0;
    nb   = 0;
    bits = '0;
    for (int i = 0; i < 200 && !latch; i++) begin
      if (sclk && !prev) begin
        if (nb < 32) bits[nb] = sdata;
        nb++;
      end
      prev = sclk;
      if (i == 21) begin
        if (spur) begin
          fb_rd_valid = 1'b1;
          fb_rd_data  = ~pix;
        end
        if (drop_en) enable = 1'b0;
        if (do_rst) begin
          chk("busy_before_rst", busy, 1);
          rst_n = 1'b0;
          #1;
          chk("rst_oe_n", oe_n, 1);
          chk("rst_sclk", sclk, 0);
          chk("rst_latch", latch, 0);
          chk("rst_busy", busy, 0);
          chk("rst_req", fb_rd_req, 0);
          chk("rst_row", fb_rd_row, 0);
          exp_q.delete();
          return;
        end
      end
      if (i == 22) fb_rd_valid = 1'b0;
      @(negedge clk);
    end
    chk("latch_seen", latch, 1);
    chk("sclk_in_latch", sclk, 0);
    chk("nbits", nb, 32);
    lc = 0;
    for (int i = 0; i < 20 && latch; i++) begin
      lc++;
      @(negedge clk);
    end
    chk("latch_len", lc, 1);
    oec = 0;
    for (int i = 0; i < HOLD + 50 && !oe_n; i++) begin
      oec++;
      @(negedge clk);
    end
    chk("oe_len", oec, HOLD);
    chk("frame_done", frame_done, (erow == 15 && eplane == 3));
    if (frame_done) frames++;
    if (exp_q.size() == 0) begin
      chk("queue_empty", exp_q.size(), 1);
    end else begin
      expw = exp_q.pop_front();
      chk("word", bits, expw);
    end
    got = bits;
  endtask

  initial begin
    logic [31:0] got, pix;
    logic        sawreq;
    int          lat;
    rst_n       = 1'b0;
    enable      = 1'b0;
    fb_rd_valid = 1'b0;
    fb_rd_data  = '0;
    repeat (3) @(negedge clk);
    chk("reset_req", fb_rd_req, 0);
    chk("reset_row", fb_rd_row, 0);
    chk("reset_sclk", sclk, 0);
    chk("reset_sdata", sdata, 0);
    chk("reset_latch", latch, 0);
    chk("reset_oe_n", oe_n, 1);
    chk("reset_busy", busy, 0);
    chk("reset_fdone", frame_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_enable", busy, 0);
    enable = 1'b1;

    for (int p = 1; p <= 3; p++) begin
      for (int r = 0; r < 16; r++) begin
        if (p == 1 && r == 5)  pix = 32'hAAAA_AAAA;
        else if (r % 3 == 0)   pix = 32'hE4E4_E4E4;
        else                   pix = $urandom;
        lat = (p == 1 && r == 3) ? 7 : 1 + (r % 3);
        run_row(r, p, pix, lat, (p == 1 && r == 3), (p == 2 && r == 9), 1'b0, got);
        if (p == 1 && r == 5) chk("row5_word", got, 32'h0020_FFFF);
        if (p == 1 && r == 3) chk("spur_word", got, 32'h0008_EEEE);
        if (r == 6) chk("ramp_cols", got[15:0], (p == 1) ? 16'hEEEE : (p == 2) ? 16'hCCCC : 16'h8888);
        if (p == 2 && r == 9) begin
          chk("busy_after_drop", busy, 0);
          sawreq = 1'b0;
          for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fb_rd_req) sawreq = 1'b1;
          end
          chk("no_req_idle", sawreq, 0);
          enable = 1'b1;
        end
      end
    end
    chk("frames", frames, 1);

    run_row(0, 1, 32'hE4E4_E4E4, 2, 1'b0, 1'b0, 1'b0, got);
    chk("wrap_word", got, 32'h0001_EEEE);

    run_row(1, 1, 32'h1234_5678, 1, 1'b0, 1'b0, 1'b1, got);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_row(0, 1, 32'h5555_5555, 3, 1'b0, 1'b0, 1'b0, got);
    chk("post_rst_word", got, 32'h0001_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
